// File: rtl/spi_slave_rx.sv
// Receive front end of the SPI slave: decodes the command bit, assembles a
// {cmd, payload} frame MSB-first and tracks the read address/data handshake.
module spi_slave_rx #(
  parameter int FRAME_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               SS_n,
  input  logic               MOSI,
  output logic [FRAME_W-1:0] rx_data,
  output logic               rx_valid,
  output logic               addr_pending,
  output logic               rd_phase,
  output logic               busy,
  output logic               frame_err
);

  localparam int CNT_W = $clog2(FRAME_W + 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CHK_CMD   = 3'd1,
    WRITE     = 3'd2,
    READ_ADD  = 3'd3,
    READ_DATA = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-2:0] shift_q, shift_d;
  logic [FRAME_W-1:0] rx_data_q, rx_data_d;
  logic               rx_valid_q, rx_valid_d;
  logic               addr_pending_q, addr_pending_d;
  logic               rd_phase_q, rd_phase_d;
  logic               busy_q, busy_d;
  logic               frame_err_q, frame_err_d;
  logic               data_state_s;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    shift_d        = shift_q;
    rx_data_d      = rx_data_q;
    rx_valid_d     = 1'b0;
    addr_pending_d = addr_pending_q;
    frame_err_d    = 1'b0;
    data_state_s   = (state_q == WRITE) || (state_q == READ_ADD) || (state_q == READ_DATA);

    // Deselect wins over everything; an unfinished frame is dropped and flagged.
    if (SS_n) begin
      state_d = IDLE;
      cnt_d   = '0;
      if ((state_q == CHK_CMD) || (data_state_s && (cnt_q < CNT_W'(FRAME_W)))) begin
        frame_err_d = 1'b1;
      end else begin
        frame_err_d = 1'b0;
      end
    end else begin
      case (state_q)
        IDLE: begin
          state_d = CHK_CMD;
          cnt_d   = '0;
        end
        CHK_CMD: begin
          cnt_d   = '0;
          shift_d = '0;
          if (!MOSI) begin
            state_d = WRITE;
          end else if (addr_pending_q) begin
            state_d = READ_DATA;
          end else begin
            state_d = READ_ADD;
          end
        end
        WRITE, READ_ADD, READ_DATA: begin
          // Counter saturates at FRAME_W, so bits after the frame are ignored.
          if (cnt_q < CNT_W'(FRAME_W)) begin
            shift_d = {shift_q[FRAME_W-3:0], MOSI};
            cnt_d   = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(FRAME_W - 1)) begin
              rx_data_d  = {shift_q, MOSI};
              rx_valid_d = 1'b1;
              if (state_q == READ_ADD) begin
                addr_pending_d = 1'b1;
              end else if (state_q == READ_DATA) begin
                addr_pending_d = 1'b0;
              end else begin
                addr_pending_d = addr_pending_q;
              end
            end else begin
              rx_valid_d = 1'b0;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end

    busy_d     = (state_d != IDLE);
    rd_phase_d = (state_d == READ_DATA);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      shift_q        <= '0;
      rx_data_q      <= '0;
      rx_valid_q     <= 1'b0;
      addr_pending_q <= 1'b0;
      rd_phase_q     <= 1'b0;
      busy_q         <= 1'b0;
      frame_err_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      shift_q        <= shift_d;
      rx_data_q      <= rx_data_d;
      rx_valid_q     <= rx_valid_d;
      addr_pending_q <= addr_pending_d;
      rd_phase_q     <= rd_phase_d;
      busy_q         <= busy_d;
      frame_err_q    <= frame_err_d;
    end
  end

  assign rx_data      = rx_data_q;
  assign rx_valid     = rx_valid_q;
  assign addr_pending = addr_pending_q;
  assign rd_phase     = rd_phase_q;
  assign busy         = busy_q;
  assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed table-driven bench for spi_slave_rx, plus hand sequences for
// command-phase abort and asynchronous reset mid-frame.
module tb_spi_slave_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ss_n = 1'b1;
  logic       mosi = 1'b0;
  logic [9:0] rx_data;
  logic       rx_valid, addr_pending, rd_phase, busy, frame_err;

  int total = 0;
  int bad = 0;
  int vcnt, ecnt, vpos, cyc;
  logic [9:0] last_data;
  logic busy_k, rd_k1, end_busy, end_rd;

  spi_slave_rx #(.FRAME_W(10)) dut (
    .clk(clk), .rst(rst), .SS_n(ss_n), .MOSI(mosi),
    .rx_data(rx_data), .rx_valid(rx_valid), .addr_pending(addr_pending),
    .rd_phase(rd_phase), .busy(busy), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       cmd;
    logic [9:0] payload;
    int         nbits;
    int         extra;
    int         exp_vcnt;
    logic [9:0] exp_data;
    logic       exp_ap;
    int         exp_ecnt;
    logic       exp_rd;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step(input logic ss, input logic m);
    @(negedge clk);
    ss_n = ss;
    mosi = m;
    @(posedge clk);
    #1;
    cyc++;
    if (rx_valid) begin
      vcnt++;
      last_data = rx_data;
      vpos = cyc;
    end
    if (frame_err) ecnt++;
  endtask

  task automatic send_frame(input logic cmd, input logic [9:0] payload,
                            input int nbits, input int extra);
    vcnt = 0; ecnt = 0; vpos = -1; cyc = -1;
    step(1'b0, 1'b0);
    busy_k = busy;
    step(1'b0, cmd);
    rd_k1 = rd_phase;
    for (int i = 0; i < nbits; i++) step(1'b0, payload[9-i]);
    for (int i = 0; i < extra; i++) step(1'b0, 1'($urandom_range(0, 1)));
    step(1'b1, 1'b0);
    end_busy = busy;
    end_rd = rd_phase;
    step(1'b1, 1'b0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{1'b0, 10'h0A5, 10, 0,  1, 10'h0A5, 1'b0, 0, 1'b0};
    vecs[1] = '{1'b1, 10'h23C, 10, 0,  1, 10'h23C, 1'b1, 0, 1'b0};
    vecs[2] = '{1'b1, 10'h3A5, 10, 8,  1, 10'h3A5, 1'b0, 0, 1'b1};
    vecs[3] = '{1'b0, 10'h155, 5,  0,  0, 10'h000, 1'b0, 1, 1'b0};
    vecs[4] = '{1'b1, 10'h155, 10, 0,  1, 10'h155, 1'b1, 0, 1'b0};
    vecs[5] = '{1'b0, 10'h3FF, 9,  0,  0, 10'h000, 1'b1, 1, 1'b0};
    vecs[6] = '{1'b0, 10'h2AA, 10, 10, 1, 10'h2AA, 1'b1, 0, 1'b0};
    vecs[7] = '{1'b1, 10'h0F0, 3,  0,  0, 10'h000, 1'b1, 1, 1'b1};
    vecs[8] = '{1'b1, 10'h0FF, 10, 0,  1, 10'h0FF, 1'b0, 0, 1'b1};

    // Reset state
    #3;
    chk("reset_rx_data", rx_data, 0);
    chk("reset_rx_valid", rx_valid, 0);
    chk("reset_addr_pending", addr_pending, 0);
    chk("reset_rd_phase", rd_phase, 0);
    chk("reset_busy", busy, 0);
    chk("reset_frame_err", frame_err, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 9; v++) begin
      send_frame(vecs[v].cmd, vecs[v].payload, vecs[v].nbits, vecs[v].extra);
      chk($sformatf("v%0d_busy_at_k", v), busy_k, 1);
      chk($sformatf("v%0d_rd_phase_at_k1", v), rd_k1, vecs[v].exp_rd);
      chk($sformatf("v%0d_valid_count", v), vcnt, vecs[v].exp_vcnt);
      if (vecs[v].exp_vcnt == 1) begin
        chk($sformatf("v%0d_valid_edge", v), vpos, 11);
        chk($sformatf("v%0d_rx_data", v), last_data, vecs[v].exp_data);
      end
      chk($sformatf("v%0d_addr_pending", v), addr_pending, vecs[v].exp_ap);
      chk($sformatf("v%0d_frame_err_count", v), ecnt, vecs[v].exp_ecnt);
      chk($sformatf("v%0d_busy_end", v), end_busy, 0);
      chk($sformatf("v%0d_rd_phase_end", v), end_rd, 0);
    end

    // SS_n rises while the command bit is expected
    vcnt = 0; ecnt = 0; cyc = -1;
    step(1'b0, 1'b0);
    step(1'b1, 1'b1);
    chk("chk_abort_err", ecnt, 1);
    chk("chk_abort_busy", busy, 0);
    step(1'b1, 1'b0);
    chk("chk_abort_err_one_cycle", ecnt, 1);
    chk("chk_abort_valid", vcnt, 0);
    chk("chk_abort_ap", addr_pending, 0);

    // Latch an address, then reset six bits into the read-data frame
    send_frame(1'b1, 10'h011, 10, 0);
    chk("pre_reset_ap", addr_pending, 1);
    vcnt = 0; ecnt = 0; cyc = -1;
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    chk("pre_reset_rd_phase", rd_phase, 1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'(i % 2));
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_rx_data", rx_data, 0);
    chk("async_rst_rx_valid", rx_valid, 0);
    chk("async_rst_ap", addr_pending, 0);
    chk("async_rst_rd_phase", rd_phase, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_frame_err", frame_err, 0);
    ss_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("post_rst_no_err", frame_err, 0);
    send_frame(1'b0, 10'h0A5, 10, 0);
    chk("post_rst_valid_count", vcnt, 1);
    chk("post_rst_rx_data", last_data, 10'h0A5);
    chk("post_rst_err_count", ecnt, 0);
    chk("post_rst_ap", addr_pending, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
# spi_slave_rx

Receive-side front end of the SPI slave: samples MOSI while SS_n is low, decodes the leading command bit, and assembles a 10-bit frame {cmd[1:0], payload[7:0]} MSB-first. Each completed frame goes to the single-port RAM controller as a parallel word with a one-cycle valid strobe. The block tracks whether a read address has been latched, so a read request is classified as address or data. It also tells the transmit path when a read-data phase is active.

## Interface
- FRAME_W, 10, bits per frame after the command bit; `rx_data` width.
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset: one clock; reset is asynchronous and active-high.
- SS_n  in  1  slave select, active low; frame boundary.
- MOSI  in  1  serial data in, sampled every `clk` edge while SS_n=0.
- rx_data  out  FRAME_W  last completed frame, MSB = first bit received after the command bit.
- rx_valid  out  1  one-cycle strobe; `rx_data` is valid in the same cycle.
- addr_pending  out  1  a read address has been received and the matching read-data frame has not yet completed.
- rd_phase  out  1  high while the FSM is in READ_DATA.
- busy  out  1  high whenever the state is not IDLE.
- frame_err  out  1  one-cycle pulse when SS_n rises before a frame completes.

## Operation
- The FSM has five states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA. The state is registered.
- SS_n=1 at any edge, in any state:
  - next state is IDLE;
  - the bit counter is cleared and no capture occurs.
  - SS_n high has priority over every other transition.
- IDLE: SS_n=0 → CHK_CMD. MOSI is ignored.
- CHK_CMD: MOSI is sampled as the command bit.
  - 0 → WRITE.
  - 1 with addr_pending=0 → READ_ADD.
  - 1 with addr_pending=1 → READ_DATA.
- WRITE, READ_ADD, READ_DATA:
  - each edge shifts MOSI into the shift register and increments the bit counter (0..FRAME_W).
  - On the edge that samples bit FRAME_W: `rx_data` ← {shift[FRAME_W-2:0], MOSI} and `rx_valid` ← 1.
  - The counter then saturates at FRAME_W. Later bits are ignored and no further `rx_valid` is produced until SS_n rises.
- Frame completion side effects (same edge as the capture):
  - READ_ADD: addr_pending ← 1.
  - READ_DATA: addr_pending ← 0.
  - WRITE: addr_pending unchanged.
- The block stays in READ_DATA after capture while SS_n=0, so `rd_phase` covers the 8-bit MISO response.
- frame_err ← 1 for one cycle when SS_n=1 is sampled in CHK_CMD, or in a data state with counter < FRAME_W. The partial frame is discarded and addr_pending is unchanged.
- The cmd field inside `rx_data[FRAME_W-1:FRAME_W-2]` is passed through. No consistency check against the command bit.

## Timing
- Reset values: state=IDLE; counter=0; shift=0; rx_data=0; rx_valid=0; addr_pending=0; rd_phase=0; busy=0; frame_err=0.
- Reset asserted mid-frame aborts the frame immediately, with no rx_valid and no frame_err. The first edge after reset release evaluates from IDLE.
- All outputs are registered; no combinational path from inputs to outputs.
- Frame latency, with SS_n first sampled low at edge k:
  - edge k: state → CHK_CMD, busy=1.
  - edge k+1: command bit sampled; state → data state.
  - edges k+2..k+FRAME_W+1: payload bits sampled.
  - edge k+FRAME_W+1: rx_valid=1 for exactly one cycle.
- rd_phase rises at edge k+1 and falls on the edge that samples SS_n=1.
- Back-to-back frames need SS_n high for at least one sampled edge between them.

## Test plan
- Write frame, SS_n low for 12 cycles, MOSI = 0 then 00_1010_0101 → single rx_valid with rx_data=10'h0A5 at edge k+11; addr_pending stays 0.
- Read-address 1 + 10_0011_1100 then read-data 1 + 11_xxxx_xxxx → frame 1: rx_data=10'h23C, addr_pending → 1. Frame 2 enters READ_DATA, rd_phase=1, addr_pending → 0 at capture.
- SS_n raised after 5 payload bits → frame_err pulse, no rx_valid, state IDLE next cycle, addr_pending unchanged.
- SS_n held low for 20 cycles in WRITE → exactly one rx_valid; extra MOSI toggles do not alter rx_data.
- rst pulsed at payload bit 6 → all outputs 0 asynchronously. A following complete frame is received correctly.
- SS_n=1 on the edge that would sample bit 10 → no capture, frame_err=1.
